// File: rtl/iact_arb_mux_pkg.sv
// Shared encodings for the iact channel arbiter/mux: selection mode and arbiter FSM state.
package iact_arb_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/iact_arb_mux_if.sv
// Activation-stream bundle of the iact mux: I_COUNT input channels, one buffered output, grant status.
interface iact_arb_mux_if #(
  parameter int DATA_WIDTH = 20,
  parameter int I_COUNT    = 3
);
  localparam int SEL_WIDTH = $clog2(I_COUNT);

  logic                          mode_i;
  logic [SEL_WIDTH-1:0]          sel_i;
  logic [I_COUNT*DATA_WIDTH-1:0] data_i;
  logic [I_COUNT-1:0]            valid_i;
  logic [I_COUNT-1:0]            last_i;
  logic [I_COUNT-1:0]            ready_o;
  logic [DATA_WIDTH-1:0]         data_o;
  logic                          valid_o;
  logic                          last_o;
  logic                          ready_i;
  logic [SEL_WIDTH-1:0]          grant_o;
  logic                          locked_o;

  modport slave (
    input  mode_i, sel_i, data_i, valid_i, last_i, ready_i,
    output ready_o, data_o, valid_o, last_o, grant_o, locked_o
  );

  modport master (
    output mode_i, sel_i, data_i, valid_i, last_i, ready_i,
    input  ready_o, data_o, valid_o, last_o, grant_o, locked_o
  );
endinterface

// File: rtl/iact_skid_fifo.sv
// Two-entry registered FIFO; head_q is always the oldest entry and holds its value when empty.
module iact_skid_fifo #(
  parameter int DATA_WIDTH = 21
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  full_o,
  output logic [1:0]            count_o
);
  logic [DATA_WIDTH-1:0] head_q, tail_q;
  logic [1:0]            count_q;
  logic                  do_push, do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= din_i;
          else                 tail_q <= din_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_q <= tail_q;
          count_q <= count_q - 2'd1;
        end
        // Simultaneous push/pop only occurs at count 1: the new beat replaces the head.
        2'b11:   head_q <= din_i;
        default: ;
      endcase
    end
  end

  assign dout_o  = head_q;
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
endmodule

// File: rtl/iact_arb_mux.sv
// Registered iact channel mux: fixed or round-robin packet arbitration into a 2-entry output buffer.
module iact_arb_mux
  import iact_arb_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int I_COUNT    = 3
) (
  input logic           clk_i,
  input logic           rst_ni,
  iact_arb_mux_if.slave bus
);
  localparam int          SEL_WIDTH = $clog2(I_COUNT);
  localparam int unsigned N_CH      = I_COUNT;

  state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]  grant_q, grant_d, rr_ptr_q, rr_ptr_d, cand;
  logic                  cand_vld;
  logic                  beat_vld, beat_last, push, buf_full;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [DATA_WIDTH:0]   head;
  logic [1:0]            buf_count;

  // Candidate for the next grant; only consumed while idle.
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    if (mode_e'(bus.mode_i) == MODE_FIXED) begin
      for (int unsigned k = 0; k < N_CH; k++)
        if (bus.sel_i == SEL_WIDTH'(k) && bus.valid_i[k]) begin
          cand     = SEL_WIDTH'(k);
          cand_vld = 1'b1;
        end
    end else begin
      for (int unsigned i = 1; i <= N_CH; i++)
        for (int unsigned k = 0; k < N_CH; k++)
          if (!cand_vld && bus.valid_i[k] && k == (32'(rr_ptr_q) + i) % N_CH) begin
            cand     = SEL_WIDTH'(k);
            cand_vld = 1'b1;
          end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    bus.ready_o = '0;
    beat_vld    = 1'b0;
    beat_last   = 1'b0;
    beat_data   = '0;
    push        = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++)
      if (grant_q == SEL_WIDTH'(k)) begin
        beat_vld  = bus.valid_i[k];
        beat_last = bus.last_i[k];
        beat_data = bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
        if (state_q == ST_LOCKED) bus.ready_o[k] = !buf_full;
      end
    case (state_q)
      ST_IDLE: begin
        if (cand_vld) begin
          grant_d = cand;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        push = beat_vld && !buf_full;
        if (push && beat_last) begin
          state_d  = ST_IDLE;
          rr_ptr_d = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= SEL_WIDTH'(I_COUNT - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  iact_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (bus.valid_o && bus.ready_i),
    .din_i   ({beat_last, beat_data}),
    .dout_o  (head),
    .full_o  (buf_full),
    .count_o (buf_count)
  );

  assign bus.valid_o  = (buf_count != 2'd0);
  assign bus.data_o   = head[DATA_WIDTH-1:0];
  assign bus.last_o   = head[DATA_WIDTH];
  assign bus.grant_o  = grant_q;
  assign bus.locked_o = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_iact_arb_mux.sv
// Bench for iact_arb_mux: per-channel packet sources checked against a packet-level arbitration model.
module tb_iact_arb_mux;
  localparam int DW  = 20;
  localparam int NCH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iact_arb_mux_if #(.DATA_WIDTH(DW), .I_COUNT(NCH)) bus ();

  iact_arb_mux #(.DATA_WIDTH(DW), .I_COUNT(NCH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mdl_ptr = NCH - 1;
  logic [DW:0] src_q[NCH][$];
  logic [DW:0] exp_q[$];
  logic [DW:0] obs_q[$];
  int acc_cyc[$], acc_ch[$], grant_log[$];
  logic [NCH-1:0] acc = '0;
  logic locked_prev = 1'b0;
  logic drv_ready = 1'b1;

  // Passive observation on the falling edge: output pops, input acceptances, new grants.
  always @(negedge clk) begin
    cyc++;
    acc = '0;
    if (rst_n) begin
      if (bus.valid_o && bus.ready_i) obs_q.push_back({bus.last_o, bus.data_o});
      for (int unsigned k = 0; k < NCH; k++)
        if (bus.valid_i[k] && bus.ready_o[k]) begin
          acc[k] = 1'b1;
          acc_cyc.push_back(cyc);
          acc_ch.push_back(int'(k));
        end
      if (bus.locked_o && !locked_prev) grant_log.push_back(int'(bus.grant_o));
      locked_prev = bus.locked_o;
    end else begin
      locked_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int unsigned k = 0; k < NCH; k++)
      if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    for (int unsigned k = 0; k < NCH; k++) begin
      bus.valid_i[k] = (src_q[k].size() != 0);
      bus.data_i[k*DW +: DW] = (src_q[k].size() != 0) ? src_q[k][0][DW-1:0] : '0;
      bus.last_i[k] = (src_q[k].size() != 0) ? src_q[k][0][DW] : 1'b0;
    end
    bus.ready_i = drv_ready;
    #1;
  endtask

  task automatic clear_logs();
    obs_q.delete();
    exp_q.delete();
    acc_cyc.delete();
    acc_ch.delete();
    grant_log.delete();
  endtask

  task automatic clear_sources();
    for (int unsigned k = 0; k < NCH; k++) src_q[k].delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_sources();
    clear_logs();
    bus.mode_i = 1'b0;
    bus.sel_i = '0;
    bus.valid_i = '0;
    bus.last_i = '0;
    bus.data_i = '0;
    drv_ready = 1'b1;
    bus.ready_i = 1'b1;
    mdl_ptr = NCH - 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic add_packet(input int ch, input int len);
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = DW'($urandom);
      src_q[ch].push_back({(i == len - 1), d});
    end
  endtask

  function automatic bit srcs_empty(input int only);
    if (only >= 0) return src_q[only].size() == 0;
    for (int unsigned k = 0; k < NCH; k++) if (src_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Packet-level model: whole packets leave in grant order; rr pointer = channel of last finished packet.
  task automatic build_expected(input bit rr, input int sel);
    logic [DW:0] m[NCH][$];
    logic [DW:0] b;
    bit found;
    int c;
    exp_q.delete();
    for (int unsigned k = 0; k < NCH; k++) m[k] = src_q[k];
    if (!rr) begin
      if (sel < NCH && m[sel].size() > 0) begin
        foreach (m[sel][i]) exp_q.push_back(m[sel][i]);
        mdl_ptr = sel;
      end
    end else begin
      while (1) begin
        found = 1'b0;
        for (int i = 1; i <= NCH && !found; i++) begin
          c = (mdl_ptr + i) % NCH;
          if (m[c].size() > 0) begin
            found = 1'b1;
            do begin
              b = m[c].pop_front();
              exp_q.push_back(b);
            end while (!b[DW]);
            mdl_ptr = c;
          end
        end
        if (!found) break;
      end
    end
  endtask

  task automatic wait_drained(input int only);
    for (int n = 0; n < 2000; n++) begin
      step();
      if (n >= 2 && !bus.valid_o && srcs_empty(only)) begin
        checks++;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout got=pending exp=drained within 2000 cycles");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if ({bus.valid_o, bus.last_o, bus.locked_o, bus.grant_o, bus.ready_o, bus.data_o} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", {bus.valid_o, bus.last_o, bus.locked_o, bus.grant_o, bus.ready_o, bus.data_o});
    end
    do_reset();
  endtask

  task automatic test_fixed_basic();
    clear_logs();
    bus.mode_i = 1'b0;
    bus.sel_i = 2'd1;
    drv_ready = 1'b1;
    src_q[1].push_back({1'b0, 20'h00033});
    src_q[1].push_back({1'b0, 20'h00034});
    src_q[1].push_back({1'b1, 20'h00035});
    step();
    checks++;
    if ({bus.locked_o, bus.ready_o} !== 4'b0_000) begin
      failures++; $display("FAIL fb_idle got=%b exp=0000", {bus.locked_o, bus.ready_o});
    end
    step();
    checks++;
    if ({bus.locked_o, bus.grant_o, bus.ready_o} !== {1'b1, 2'd1, 3'b010}) begin
      failures++; $display("FAIL fb_lock got=%b exp=101010", {bus.locked_o, bus.grant_o, bus.ready_o});
    end
    step();
    checks++;
    if ({bus.valid_o, bus.data_o, bus.ready_o} !== {1'b1, 20'h00033, 3'b010}) begin
      failures++; $display("FAIL fb_beat0 got=%h exp=%h", {bus.valid_o, bus.data_o, bus.ready_o}, {1'b1, 20'h00033, 3'b010});
    end
    step();
    checks++;
    if ({bus.valid_o, bus.data_o, bus.ready_o} !== {1'b1, 20'h00034, 3'b010}) begin
      failures++; $display("FAIL fb_beat1 got=%h exp=%h", {bus.valid_o, bus.data_o, bus.ready_o}, {1'b1, 20'h00034, 3'b010});
    end
    step();
    checks++;
    if ({bus.valid_o, bus.last_o, bus.data_o, bus.locked_o} !== {2'b11, 20'h00035, 1'b0}) begin
      failures++; $display("FAIL fb_beat2 got=%h exp=%h", {bus.valid_o, bus.last_o, bus.data_o, bus.locked_o}, {2'b11, 20'h00035, 1'b0});
    end
    step();
    checks++;
    if (bus.valid_o !== 1'b0) begin
      failures++; $display("FAIL fb_drain got=%b exp=0", bus.valid_o);
    end
    mdl_ptr = 1;
  endtask

  task automatic test_bad_sel();
    bus.mode_i = 1'b0;
    bus.sel_i = 2'd3;
    for (int k = 0; k < NCH; k++) add_packet(k, 1);
    repeat (10) begin
      step();
      checks++;
      if ({bus.ready_o, bus.valid_o, bus.locked_o} !== 5'b0) begin
        failures++; $display("FAIL bad_sel got=%b exp=00000", {bus.ready_o, bus.valid_o, bus.locked_o});
      end
    end
    clear_sources();
    step();
  endtask

  task automatic test_rr();
    int exp_g[$] = '{0, 1, 2, 0};
    bit ok;
    do_reset();
    bus.mode_i = 1'b1;
    src_q[0].push_back({1'b1, 20'h000A0});
    src_q[0].push_back({1'b1, 20'h000A0});
    src_q[1].push_back({1'b1, 20'h000A1});
    src_q[2].push_back({1'b1, 20'h000A2});
    build_expected(1'b1, 0);
    wait_drained(-1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rr_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rr_beat%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    ok = (grant_log.size() == exp_g.size());
    foreach (exp_g[i]) if (i < grant_log.size() && grant_log[i] != exp_g[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rr_grants got=%p exp=%p", grant_log, exp_g);
    end
  endtask

  task automatic test_stall();
    clear_logs();
    bus.mode_i = 1'b0;
    bus.sel_i = 2'd2;
    drv_ready = 1'b0;
    add_packet(2, 4);
    build_expected(1'b0, 2);
    repeat (6) step();
    checks++;
    if (acc_ch.size() != 2) begin
      failures++; $display("FAIL stall_accepted got=%0d exp=2", acc_ch.size());
    end
    checks++;
    if ({bus.ready_o, bus.valid_o, bus.locked_o} !== 5'b000_11) begin
      failures++; $display("FAIL stall_ready got=%b exp=00011", {bus.ready_o, bus.valid_o, bus.locked_o});
    end
    drv_ready = 1'b1;
    wait_drained(2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL stall_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL stall_beat%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_change();
    int last0 = -1;
    int first2 = -1;
    clear_logs();
    bus.mode_i = 1'b0;
    bus.sel_i = 2'd0;
    drv_ready = 1'b1;
    add_packet(0, 3);
    add_packet(2, 2);
    foreach (src_q[0][i]) exp_q.push_back(src_q[0][i]);
    foreach (src_q[2][i]) exp_q.push_back(src_q[2][i]);
    mdl_ptr = 2;
    step();
    step();
    bus.sel_i = 2'd2;
    wait_drained(-1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL mid_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL mid_beat%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    foreach (acc_ch[i]) begin
      if (acc_ch[i] == 0) last0 = acc_cyc[i];
      if (acc_ch[i] == 2 && first2 < 0) first2 = acc_cyc[i];
    end
    checks++;
    if (first2 - last0 != 2) begin
      failures++; $display("FAIL mid_bubble got=%0d exp=2", first2 - last0);
    end
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
      failures++; $display("FAIL mid_grants got=%p exp=0,2", grant_log);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    bus.mode_i = 1'b0;
    bus.sel_i = 2'd1;
    drv_ready = 1'b0;
    add_packet(1, 5);
    repeat (4) step();
    checks++;
    if ({bus.valid_o, bus.locked_o, bus.grant_o} !== 4'b1101) begin
      failures++; $display("FAIL rmid_pre got=%b exp=1101", {bus.valid_o, bus.locked_o, bus.grant_o});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.valid_o, bus.ready_o, bus.locked_o, bus.grant_o, bus.last_o, bus.data_o} !== '0) begin
      failures++; $display("FAIL rmid_async got=%h exp=0", {bus.valid_o, bus.ready_o, bus.locked_o, bus.grant_o, bus.last_o, bus.data_o});
    end
    do_reset();
    bus.mode_i = 1'b1;
    for (int k = 0; k < NCH; k++) add_packet(k, 1);
    build_expected(1'b1, 0);
    wait_drained(-1);
    checks++;
    if (grant_log.size() == 0 || grant_log[0] != 0) begin
      failures++; $display("FAIL rmid_first_grant got=%p exp=0 first", grant_log);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rmid_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rmid_beat%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit rr;
    int sel, only, n;
    logic [NCH-1:0] gmask;
    for (int it = 0; it < 12; it++) begin
      clear_logs();
      rr = (it % 2 == 0);
      sel = $urandom_range(0, NCH - 1);
      only = rr ? -1 : sel;
      bus.mode_i = rr;
      bus.sel_i = 2'(sel);
      for (int k = 0; k < NCH; k++)
        repeat ($urandom_range(0, 2)) add_packet(k, $urandom_range(1, 4));
      build_expected(rr, sel);
      for (n = 0; n < 3000; n++) begin
        drv_ready = ($urandom_range(0, 3) != 0);
        step();
        gmask = bus.locked_o ? (NCH'(1) << bus.grant_o) : '0;
        checks++;
        if ((bus.ready_o & ~gmask) !== '0) begin
          failures++; $display("FAIL rand_ready_onehot got=%b exp_mask=%b", bus.ready_o, gmask);
        end
        if (n >= 2 && !bus.valid_o && srcs_empty(only)) break;
      end
      checks++;
      if (n >= 3000) begin
        failures++; $display("FAIL rand_timeout got=pending exp=drained iter=%0d", it);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++; $display("FAIL rand_count iter=%0d got=%0d exp=%0d", it, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL rand_beat iter=%0d idx=%0d got=%h exp=%h", it, i, obs_q[i], exp_q[i]);
        end
      end
      clear_sources();
      drv_ready = 1'b1;
      step();
    end
  endtask

  initial begin
    bus.mode_i = 1'b0;
    bus.sel_i = '0;
    bus.valid_i = '0;
    bus.last_i = '0;
    bus.data_i = '0;
    bus.ready_i = 1'b1;
    test_reset();
    test_fixed_basic();
    test_bad_sel();
    test_rr();
    test_stall();
    test_mid_change();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation did not finish");
  end
endmodule
